// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: bundles the write-port arbiter's bus signals.
//   Requester A (pipeline writeback): a_valid, a_rd, a_data
//   Requester B (long-latency unit):  b_valid, b_ready, b_rd, b_data
//   Decode issue / hazard query:      iss_valid, iss_rd, q_rs1, q_rs2, q_rd, stall
//   Register-file write port:         rf_we, rf_rd, rf_wdata
//   Status:                           pend_cnt
// Modports: master (the surrounding core / bench), slave (the arbiter).
interface rf_wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      q_rs1;
    logic [4:0]      q_rs2;
    logic [4:0]      q_rd;
    logic            stall;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [5:0]      pend_cnt;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        output iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
        input  b_ready, stall, rf_we, rf_rd, rf_wdata, pend_cnt
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        input  iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
        output b_ready, stall, rf_we, rf_rd, rf_wdata, pend_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between the
// in-order pipeline writeback (A, never stalled, fixed priority) and the
// long-latency load/multiply unit (B, valid/ready, buffered in a small FIFO).
// A per-register pending scoreboard tracks destinations still owed by B and
// drives the decode-stage hazard stall.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - rf_wb_arbiter_if.slave (A/B requesters, issue/query, RF write port,
//          pend_cnt)
//
// Parameters:
//   XLEN       - data width (must match the interface instance)
//   FIFO_DEPTH - B holding-buffer entries, power of two, >= 2
//
// Optional feature macro: RF_WB_BYPASS_EN
//   Defined: with the FIFO empty and A idle, an offered B result is written
//   to the port in the same cycle instead of being buffered.
//   Undefined: every B result goes through the FIFO (min latency one cycle).
module rf_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Holding FIFO storage and pointers.
    logic [4:0]      mem_rd_q   [FIFO_DEPTH];
    logic [4:0]      mem_rd_d   [FIFO_DEPTH];
    logic [XLEN-1:0] mem_data_q [FIFO_DEPTH];
    logic [XLEN-1:0] mem_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Scoreboard.
    logic [31:0] pend_q, pend_d;
    logic [5:0]  pend_cnt_q, pend_cnt_d;

    logic            full, empty;
    logic            b_ready;
    logic            accept, push, pop, bypass;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            b_commit;
    logic [4:0]      clr_rd;
    logic            stall;

    // Handshake and port arbitration.
    always_comb begin
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        empty     = (count_q == '0);
        b_ready   = !full && !rst;
        accept    = bus.b_valid && b_ready;
        head_rd   = mem_rd_q[rd_ptr_q];
        head_data = mem_data_q[rd_ptr_q];
`ifdef RF_WB_BYPASS_EN
        bypass    = empty && !bus.a_valid && accept;
`else
        bypass    = 1'b0;
`endif
        push      = accept && !bypass;
        // A always wins; the head only drains in cycles where A is idle.
        pop       = !bus.a_valid && !empty;

        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (bus.a_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.a_rd;
            sel_data  = bus.a_data;
        end else if (!empty) begin
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = head_data;
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_rd    = bus.b_rd;
            sel_data  = bus.b_data;
        end

        // A B result targeting x0 is still consumed; it just never writes.
        b_commit = (pop || bypass) && !rst;
        clr_rd   = pop ? head_rd : bus.b_rd;
    end

    // FIFO next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_rd_d[i]   = mem_rd_q[i];
            mem_data_d[i] = mem_data_q[i];
        end
        if (push) begin
            mem_rd_d[wr_ptr_q]   = bus.b_rd;
            mem_data_d[wr_ptr_q] = bus.b_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard next state; the set is applied last so it wins over a
    // same-cycle clear of the same register.
    always_comb begin
        pend_d = pend_q;
        if (b_commit && clr_rd != 5'd0) begin
            pend_d[clr_rd] = 1'b0;
        end
        if (bus.iss_valid && bus.iss_rd != 5'd0) begin
            pend_d[bus.iss_rd] = 1'b1;
        end
        pend_cnt_d = '0;
        for (int i = 0; i < 32; i++) begin
            pend_cnt_d = pend_cnt_d + {5'd0, pend_d[i]};
        end
    end

    // Hazard query; x0 is never pending.
    always_comb begin
        stall = !rst && (((bus.q_rs1 != 5'd0) && pend_q[bus.q_rs1]) ||
                         ((bus.q_rs2 != 5'd0) && pend_q[bus.q_rs2]) ||
                         ((bus.q_rd  != 5'd0) && pend_q[bus.q_rd]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_rd_q[i]   <= mem_rd_d[i];
            mem_data_q[i] <= mem_data_d[i];
        end
    end

    assign bus.b_ready  = b_ready;
    assign bus.stall    = stall;
    assign bus.rf_we    = sel_valid && (sel_rd != 5'd0) && !rst;
    assign bus.rf_rd    = sel_rd;
    assign bus.rf_wdata = sel_data;
    assign bus.pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_rf_wb_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rf_wb_arbiter_if #(.XLEN(32)) bus ();

    rf_wb_arbiter #(
        .XLEN       (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.a_valid   = 1'b0;
        bus.a_rd      = 5'd0;
        bus.a_data    = 32'd0;
        bus.b_valid   = 1'b0;
        bus.b_rd      = 5'd0;
        bus.b_data    = 32'd0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
        bus.q_rs1     = 5'd0;
        bus.q_rs2     = 5'd0;
        bus.q_rd      = 5'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd4;
        bus.b_data  = 32'h1234;
        bus.q_rs1   = 5'd4;
        #1;
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL reset_rf_we0: got %b want 0", bus.rf_we);
        end
        total++;
        if (bus.b_ready !== 1'b0) begin
            bad++; $display("FAIL reset_b_ready0: got %b want 0", bus.b_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall: got %b want 0", bus.stall);
        end
        total++;
        if (bus.pend_cnt !== 6'd0) begin
            bad++; $display("FAIL reset_pend_cnt: got %0d want 0", bus.pend_cnt);
        end
        total++;
        if (bus.b_ready !== 1'b0) begin
            bad++; $display("FAIL reset_b_ready1: got %b want 0", bus.b_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        total++;
        if (bus.b_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_b_ready: got %b want 1", bus.b_ready);
        end
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL post_reset_rf_we: got %b want 0", bus.rf_we);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd5;
        bus.q_rs1     = 5'd5;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++; $display("FAIL sb_stall_before: got %b want 0", bus.stall);
        end
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.b_valid   = 1'b1;
        bus.b_rd      = 5'd5;
        bus.b_data    = 32'hDEADBEEF;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++; $display("FAIL sb_stall_set: got %b want 1", bus.stall);
        end
        total++;
        if (bus.pend_cnt !== 6'd1) begin
            bad++; $display("FAIL sb_pend_cnt1: got %0d want 1", bus.pend_cnt);
        end
`ifndef RF_WB_BYPASS_EN
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL sb_no_same_cycle: got %b want 0", bus.rf_we);
        end
        @(negedge clk);
        bus.b_valid = 1'b0;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++; $display("FAIL sb_stall_held: got %b want 1", bus.stall);
        end
`endif
        total++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5) begin
            bad++; $display("FAIL sb_b_write: got we=%b rd=%0d want we=1 rd=5",
                            bus.rf_we, bus.rf_rd);
        end
        total++;
        if (bus.rf_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL sb_b_data: got %h want deadbeef", bus.rf_wdata);
        end
        @(negedge clk);
        bus.b_valid = 1'b0;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++; $display("FAIL sb_stall_clear: got %b want 0", bus.stall);
        end
        total++;
        if (bus.pend_cnt !== 6'd0) begin
            bad++; $display("FAIL sb_pend_cnt0: got %0d want 0", bus.pend_cnt);
        end
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL sb_idle_after: got %b want 0", bus.rf_we);
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        idle();
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd3;
        bus.a_data  = 32'h11;
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd7;
        bus.b_data  = 32'h22;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin
                @(negedge clk);
                bus.b_valid = 1'b0;
            end
            #1;
            total++;
            if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'h11) begin
                bad++; $display("FAIL conflict_a_c%0d: got we=%b rd=%0d d=%h want 1/3/11",
                                c, bus.rf_we, bus.rf_rd, bus.rf_wdata);
            end
        end
        @(negedge clk);
        bus.a_valid = 1'b0;
        #1;
        total++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== 32'h22) begin
            bad++; $display("FAIL conflict_b_c4: got we=%b rd=%0d d=%h want 1/7/22",
                            bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL conflict_drained: got %b want 0", bus.rf_we);
        end
    endtask

    task automatic test_full();
        logic [4:0]  exp_rd   [3];
        logic [31:0] exp_data [3];
        exp_rd[0] = 5'd10; exp_data[0] = 32'hA;
        exp_rd[1] = 5'd11; exp_data[1] = 32'hB;
        exp_rd[2] = 5'd12; exp_data[2] = 32'hC;
        @(negedge clk);
        idle();
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd1;
        bus.a_data  = 32'h100;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            bus.b_valid = 1'b1;
            bus.b_rd    = exp_rd[k];
            bus.b_data  = exp_data[k];
            #1;
            total++;
            if (bus.b_ready !== (k < 2)) begin
                bad++; $display("FAIL full_b_ready_k%0d: got %b want %b",
                                k, bus.b_ready, (k < 2));
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.b_ready !== 1'b0) begin
            bad++; $display("FAIL full_b_ready_hold: got %b want 0", bus.b_ready);
        end
        @(negedge clk);
        bus.a_valid = 1'b0;
        #1;
        total++;
        if (bus.rf_rd !== 5'd10 || bus.rf_wdata !== 32'hA || bus.rf_we !== 1'b1) begin
            bad++; $display("FAIL full_drain0: got we=%b rd=%0d d=%h want 1/10/a",
                            bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.b_ready !== 1'b1) begin
            bad++; $display("FAIL full_b_ready_reopen: got %b want 1", bus.b_ready);
        end
        total++;
        if (bus.rf_rd !== 5'd11 || bus.rf_wdata !== 32'hB) begin
            bad++; $display("FAIL full_drain1: got rd=%0d d=%h want 11/b",
                            bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        bus.b_valid = 1'b0;
        #1;
        total++;
        if (bus.rf_rd !== 5'd12 || bus.rf_wdata !== 32'hC || bus.rf_we !== 1'b1) begin
            bad++; $display("FAIL full_drain2: got we=%b rd=%0d d=%h want 1/12/c",
                            bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL full_empty: got %b want 0", bus.rf_we);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.b_valid   = 1'b1;
        bus.b_rd      = 5'd0;
        bus.b_data    = 32'h55;
        #1;
        total++;
        if (bus.pend_cnt !== 6'd0) begin
            bad++; $display("FAIL x0_pend_cnt: got %0d want 0", bus.pend_cnt);
        end
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL x0_b_we_c1: got %b want 0", bus.rf_we);
        end
        @(negedge clk);
        bus.b_valid = 1'b0;
        #1;
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL x0_b_we_c2: got %b want 0", bus.rf_we);
        end
        @(negedge clk);
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd0;
        bus.a_data  = 32'h77;
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd13;
        bus.b_data  = 32'h66;
        #1;
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL x0_a_we: got %b want 0", bus.rf_we);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd13 || bus.rf_wdata !== 32'h66) begin
            bad++; $display("FAIL x0_popped: got we=%b rd=%0d d=%h want 1/13/66",
                            bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL x0_drained: got %b want 0", bus.rf_we);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        bus.q_rs2     = 5'd9;
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.b_valid   = 1'b1;
        bus.b_rd      = 5'd9;
        bus.b_data    = 32'h99;
        #1;
        total++;
        if (bus.pend_cnt !== 6'd1) begin
            bad++; $display("FAIL same_pend_before: got %0d want 1", bus.pend_cnt);
        end
`ifndef RF_WB_BYPASS_EN
        @(negedge clk);
        bus.b_valid = 1'b0;
`endif
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        #1;
        total++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd9) begin
            bad++; $display("FAIL same_commit: got we=%b rd=%0d want 1/9",
                            bus.rf_we, bus.rf_rd);
        end
        @(negedge clk);
        idle();
        bus.q_rs2 = 5'd9;
        #1;
        total++;
        if (bus.pend_cnt !== 6'd1) begin
            bad++; $display("FAIL same_pend_after: got %0d want 1", bus.pend_cnt);
        end
        total++;
        if (bus.stall !== 1'b1) begin
            bad++; $display("FAIL same_stall: got %b want 1", bus.stall);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_scoreboard();
        test_conflict();
        test_full();
        test_x0();
        test_same_cycle();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
